// File: rtl/video_cfg_sequencer_if.sv
// Register-bank, frame-timing and buffer-swap signals shared between the
// host/timing side and the configuration sequencer.
interface video_cfg_sequencer_if;
  logic [31:0] cfg_ctrl;
  logic [31:0] cfg_front;
  logic [31:0] cfg_back;
  logic [31:0] cfg_res;
  logic        commit;
  logic        swap_req;
  logic        vblank;
  logic        swap_ready;
  logic        act_enable;
  logic [31:0] act_buf_addr;
  logic [15:0] act_width;
  logic [15:0] act_height;
  logic        swap_valid;
  logic        irq;
  logic [31:0] status;

  // Host / timing generator / pixel fetcher side.
  modport master (
    output cfg_ctrl, cfg_front, cfg_back, cfg_res,
    output commit, swap_req, vblank, swap_ready,
    input  act_enable, act_buf_addr, act_width, act_height,
    input  swap_valid, irq, status
  );

  // Sequencer side.
  modport slave (
    input  cfg_ctrl, cfg_front, cfg_back, cfg_res,
    input  commit, swap_req, vblank, swap_ready,
    output act_enable, act_buf_addr, act_width, act_height,
    output swap_valid, irq, status
  );
endinterface

// File: rtl/video_cfg_sequencer.sv
// Video configuration sequencer: stages register-bank writes and applies them
// atomically at vblank, runs the front/back buffer swap handshake with the
// pixel fetcher, and reports status plus a per-swap interrupt pulse.
module video_cfg_sequencer #(
  parameter int unsigned FCNT_W  = 16,
  parameter int unsigned MIN_DIM = 1
) (
  input logic                  clk,
  input logic                  reset,
  video_cfg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

  localparam logic [15:0] MIN_DIM_W = 16'(MIN_DIM);

  state_t              state_q, state_d;
  logic                cpend_q, cpend_d;
  logic                spend_q, spend_d;
  logic                buf_sel_q, buf_sel_d;
  logic                err_q, err_d;
  logic                irq_q, irq_d;
  logic                act_enable_q, act_enable_d;
  logic [31:0]         act_addr_q, act_addr_d;
  logic [15:0]         act_width_q, act_width_d;
  logic [15:0]         act_height_q, act_height_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic [15:0]         cfg_width;
  logic [15:0]         cfg_height;
  logic                dims_ok;
  logic                commit_ok;
  logic                commit_bad;
  logic                apply_cfg;
  logic                unused_ctrl;

  assign cfg_width   = bus.cfg_res[15:0];
  assign cfg_height  = bus.cfg_res[31:16];
  assign dims_ok     = (cfg_width >= MIN_DIM_W) && (cfg_height >= MIN_DIM_W);
  assign commit_ok   = bus.commit && dims_ok;
  assign commit_bad  = bus.commit && !dims_ok;
  // Only the enable bit of the control register matters to this block.
  assign unused_ctrl = ^bus.cfg_ctrl[31:1];

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    cpend_d      = cpend_q;
    spend_d      = spend_q;
    buf_sel_d    = buf_sel_q;
    err_d        = err_q;
    irq_d        = 1'b0;
    fcnt_d       = fcnt_q;
    act_enable_d = act_enable_q;
    act_addr_d   = act_addr_q;
    act_width_d  = act_width_q;
    act_height_d = act_height_q;
    apply_cfg    = 1'b0;

    // A rejected commit flags the error; only an accepted one clears it.
    if (commit_bad) begin
      err_d = 1'b1;
    end else if (commit_ok) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Display is off, so a commit applies straight away.
        if (commit_ok) begin
          apply_cfg = 1'b1;
          if (bus.cfg_ctrl[0]) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (commit_ok) begin
          cpend_d = 1'b1;
        end
        if (bus.swap_req) begin
          spend_d = 1'b1;
        end
        // Decisions use the flags as they stood before this cycle, so a
        // commit or swap_req coincident with vblank waits for the next one.
        if (bus.vblank) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (cpend_q) begin
            apply_cfg = 1'b1;
            cpend_d   = commit_ok;
            if (!bus.cfg_ctrl[0]) begin
              state_d = IDLE;
              cpend_d = 1'b0;
              spend_d = 1'b0;
            end
          end else if (spend_q) begin
            state_d = SWAP;
          end
        end
      end

      SWAP: begin
        // Commits are staged for a later vblank; extra swap_req is absorbed.
        if (commit_ok) begin
          cpend_d = 1'b1;
        end
        if (bus.vblank) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
        if (bus.swap_ready) begin
          buf_sel_d  = ~buf_sel_q;
          act_addr_d = buf_sel_q ? bus.cfg_front : bus.cfg_back;
          spend_d    = 1'b0;
          irq_d      = 1'b1;
          state_d    = RUN;
        end
      end

      default: state_d = IDLE;
    endcase

    if (apply_cfg) begin
      act_enable_d = bus.cfg_ctrl[0];
      act_addr_d   = buf_sel_q ? bus.cfg_back : bus.cfg_front;
      act_width_d  = cfg_width;
      act_height_d = cfg_height;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement or block order.
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending flags, error, buffer select, frame counter and applied config.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpend_q      <= 1'b0;
      spend_q      <= 1'b0;
      buf_sel_q    <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      fcnt_q       <= '0;
      act_enable_q <= 1'b0;
      act_addr_q   <= '0;
      act_width_q  <= '0;
      act_height_q <= '0;
    end else begin
      cpend_q      <= cpend_d;
      spend_q      <= spend_d;
      buf_sel_q    <= buf_sel_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
      fcnt_q       <= fcnt_d;
      act_enable_q <= act_enable_d;
      act_addr_q   <= act_addr_d;
      act_width_q  <= act_width_d;
      act_height_q <= act_height_d;
    end
  end

  // The swap offer is a pure state decode, so reset removes it at once.
  assign bus.swap_valid   = (state_q == SWAP);
  assign bus.irq          = irq_q;
  assign bus.act_enable   = act_enable_q;
  assign bus.act_buf_addr = act_addr_q;
  assign bus.act_width    = act_width_q;
  assign bus.act_height   = act_height_q;
  assign bus.status       = {16'(fcnt_q), 12'h000, err_q, buf_sel_q, spend_q, cpend_q};

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Self-checking bench for video_cfg_sequencer: directed scenarios plus a
// randomized phase, with a queue-based scoreboard fed by a reference model.
module tb_video_cfg_sequencer;

  localparam int unsigned MIN_DIM = 1;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [15:0] w;
    logic [15:0] h;
    logic        sv;
    logic        irq;
    logic [31:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  video_cfg_sequencer_if bus ();

  video_cfg_sequencer #(.FCNT_W(16), .MIN_DIM(MIN_DIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];

  // Register values the next cycle() call presents to the DUT.
  logic [31:0] n_ctrl, n_front, n_back, n_res;

  // Reference model: the observable configuration and handshake situation.
  bit          m_on;       // display running (enable applied)
  bit          m_offer;    // swap offered to the fetcher
  bit          m_cpend, m_spend, m_bsel, m_err, m_en, m_irq;
  logic [31:0] m_addr;
  logic [15:0] m_w, m_h;
  int unsigned m_frames;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_offer = 0; m_cpend = 0; m_spend = 0; m_bsel = 0;
    m_err = 0; m_en = 0; m_irq = 0; m_addr = '0; m_w = '0; m_h = '0;
    m_frames = 0;
  endtask

  function automatic logic [31:0] pick_addr(input bit sel);
    return sel ? bus.cfg_back : bus.cfg_front;
  endfunction

  task automatic load_cfg();
    m_en   = bus.cfg_ctrl[0];
    m_addr = pick_addr(m_bsel);
    m_w    = bus.cfg_res[15:0];
    m_h    = bus.cfg_res[31:16];
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input bit c, input bit s, input bit v, input bit r);
    bit ok, cp_before, sp_before;
    ok = (int'(bus.cfg_res[15:0]) >= MIN_DIM) && (int'(bus.cfg_res[31:16]) >= MIN_DIM);
    cp_before = m_cpend;
    sp_before = m_spend;
    m_irq = 0;
    if (c) m_err = !ok;
    if (!m_on) begin
      if (c && ok) begin
        load_cfg();
        m_on = m_en;
      end
    end else if (m_offer) begin
      if (c && ok) m_cpend = 1;
      if (v) m_frames++;
      if (r) begin
        m_bsel  = !m_bsel;
        m_addr  = pick_addr(m_bsel);
        m_spend = 0;
        m_irq   = 1;
        m_offer = 0;
      end
    end else begin
      if (c && ok) m_cpend = 1;
      if (s) m_spend = 1;
      if (v) begin
        m_frames++;
        if (cp_before) begin
          load_cfg();
          m_cpend = c && ok;
          if (!m_en) begin
            m_on = 0; m_cpend = 0; m_spend = 0;
          end
        end else if (sp_before) begin
          m_offer = 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus away from the edge and queue the expected
  // outputs for after the coming edge.
  task automatic cycle(input bit c, input bit s, input bit v, input bit r);
    exp_t e;
    @(posedge clk);
    #2;
    bus.cfg_ctrl   = n_ctrl;
    bus.cfg_front  = n_front;
    bus.cfg_back   = n_back;
    bus.cfg_res    = n_res;
    bus.commit     = c;
    bus.swap_req   = s;
    bus.vblank     = v;
    bus.swap_ready = r;
    model_step(c, s, v, r);
    e.en   = m_en;
    e.addr = m_addr;
    e.w    = m_w;
    e.h    = m_h;
    e.sv   = m_offer;
    e.irq  = m_irq;
    e.st   = {m_frames[15:0], 12'h000, m_err, m_bsel, m_spend, m_cpend};
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_act_enable"}, 32'(bus.act_enable), 32'h0);
    check({tag, "_act_buf_addr"}, bus.act_buf_addr, 32'h0);
    check({tag, "_act_width"}, 32'(bus.act_width), 32'h0);
    check({tag, "_act_height"}, 32'(bus.act_height), 32'h0);
    check({tag, "_swap_valid"}, 32'(bus.swap_valid), 32'h0);
    check({tag, "_irq"}, 32'(bus.irq), 32'h0);
    check({tag, "_status"}, bus.status, 32'h0);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("act_enable", 32'(bus.act_enable), 32'(e.en));
        check("act_buf_addr", bus.act_buf_addr, e.addr);
        check("act_width", 32'(bus.act_width), 32'(e.w));
        check("act_height", 32'(bus.act_height), 32'(e.h));
        check("swap_valid", 32'(bus.swap_valid), 32'(e.sv));
        check("irq", 32'(bus.irq), 32'(e.irq));
        check("status", bus.status, e.st);
      end
    end
  end

  initial begin
    int sv_cycles;
    bus.commit = 0; bus.swap_req = 0; bus.vblank = 0; bus.swap_ready = 0;
    bus.cfg_ctrl = '0; bus.cfg_front = '0; bus.cfg_back = '0; bus.cfg_res = '0;
    n_ctrl = '0; n_front = '0; n_back = '0; n_res = '0;
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // 1: commit in IDLE with enable -> 640x480 applied one cycle later.
    n_ctrl = 32'h1; n_front = 32'h1000; n_back = 32'h2000; n_res = 32'h01E0_0280;
    cycle(1, 0, 0, 0);
    idle(1);
    check("t1_width", 32'(bus.act_width), 32'd640);
    check("t1_height", 32'(bus.act_height), 32'd480);
    check("t1_enable", 32'(bus.act_enable), 32'h1);

    // 2: staged commit waits for vblank.
    n_res = 32'h0258_0320;
    cycle(1, 0, 0, 0);
    idle(3);
    check("t2_width_held", 32'(bus.act_width), 32'd640);
    check("t2_cpend", 32'(bus.status[0]), 32'h1);
    cycle(0, 0, 1, 0);
    idle(1);
    check("t2_width", 32'(bus.act_width), 32'd800);
    check("t2_height", 32'(bus.act_height), 32'd600);
    check("t2_cpend_clr", 32'(bus.status[0]), 32'h0);
    check("t2_frames", 32'(bus.status[31:16]), 32'h1);

    // 3: swap with swap_ready held off so the offer lasts 4 cycles.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    sv_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, i == 3);
      if (bus.swap_valid) sv_cycles++;
    end
    idle(1);
    check("t3_sv_cycles", 32'(sv_cycles), 32'd4);
    check("t3_addr", bus.act_buf_addr, 32'h2000);
    check("t3_irq", 32'(bus.irq), 32'h1);
    check("t3_bufsel", 32'(bus.status[2]), 32'h1);
    idle(1);
    check("t3_irq_once", 32'(bus.irq), 32'h0);

    // 4: zero width is rejected; a valid commit clears the error.
    n_res = 32'h0258_0000;
    cycle(1, 0, 0, 0);
    idle(1);
    check("t4_err", 32'(bus.status[3]), 32'h1);
    check("t4_width_held", 32'(bus.act_width), 32'd800);
    n_res = 32'h0300_0400;
    cycle(1, 0, 0, 0);
    idle(1);
    check("t4_err_clr", 32'(bus.status[3]), 32'h0);
    cycle(0, 0, 1, 0);
    idle(1);
    check("t4_width", 32'(bus.act_width), 32'd1024);

    // 5: commit coincident with vblank applies at the following vblank.
    n_res = 32'h00F0_0140;
    cycle(1, 0, 1, 0);
    idle(1);
    check("t5_width_held", 32'(bus.act_width), 32'd1024);
    cycle(0, 0, 1, 0);
    idle(1);
    check("t5_width", 32'(bus.act_width), 32'd320);
    while (m_frames[15:0] != 16'hFFFF) cycle(0, 0, 1, 0);
    idle(1);
    check("t5_fcnt_max", 32'(bus.status[31:16]), 32'hFFFF);
    cycle(0, 0, 1, 0);
    idle(1);
    check("t5_fcnt_wrap", 32'(bus.status[31:16]), 32'h0);

    // 6: reset while swap is offered drops everything immediately.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    idle(1);
    check("t6_sv_before", 32'(bus.swap_valid), 32'h1);
    reset = 1'b0;
    sb.delete();
    bus.commit = 0; bus.swap_req = 0; bus.vblank = 0; bus.swap_ready = 0;
    #1 check_all_zero("t6_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    n_ctrl = 32'h1; n_front = 32'hA000; n_back = 32'hB000; n_res = 32'h0010_0010;
    cycle(1, 0, 0, 0);
    idle(1);
    check("t6_bufsel0_addr", bus.act_buf_addr, 32'hA000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        n_res[15:0]  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        n_res[31:16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      if ($urandom_range(0, 31) == 0) n_ctrl = {$urandom_range(0, 7) != 0 ? 31'h0 : 31'h7, $urandom_range(0, 5) != 0};
      if ($urandom_range(0, 15) == 0) n_front = $urandom;
      if ($urandom_range(0, 15) == 0) n_back = $urandom;
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2);
    @(posedge clk);
    #3;
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
